phase1_driver: RTL

Phase-1 sequencer: the responder side of the phase handshake issued by the MD control unit. On `phase1_ready`, it snapshots the active position-cache bank (`double_buffer`) and the particle count for the current cell. It then streams one read request per particle into the force pipeline with a valid/ready handshake, waits for the pipeline to drain, and holds `phase1_done` until the control unit leaves phase 1.

---
 rtl/phase1_driver_if.sv | 33 +++
 rtl/phase1_driver.sv | 98 +++++++++
 2 files changed

// File: rtl/phase1_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : phase1_driver_if
// Brief    : Read-request bus between the phase-1 sequencer and the force
//            pipeline (valid/ready requests plus pipeline occupancy).
// Revision : 1.0 - initial release
// ============================================================================
interface phase1_driver_if #(
    parameter int PADDR_W = 7
);
    logic               rd_valid;
    logic               rd_ready;
    logic [PADDR_W:0]   rd_addr;
    logic               rd_last;
    logic               pipe_busy;

    modport master (
        output rd_valid,
        output rd_addr,
        output rd_last,
        input  rd_ready,
        input  pipe_busy
    );

    modport slave (
        input  rd_valid,
        input  rd_addr,
        input  rd_last,
        output rd_ready,
        output pipe_busy
    );
endinterface
`default_nettype wire

// File: rtl/phase1_driver.sv
`default_nettype none
// ============================================================================
// Module   : phase1_driver
// Brief    : Phase-1 sequencer; snapshots bank and cell count, streams one
//            read request per particle, drains the pipeline, reports done.
// Revision : 1.0 - initial release
// ============================================================================
module phase1_driver #(
    parameter int PADDR_W      = 7,
    parameter int DRAIN_CYCLES = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             phase1_ready,
    input  logic             double_buffer,
    input  logic [PADDR_W:0] cell_count,
    output logic             phase1_done,
    phase1_driver_if.master  rd
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [PADDR_W:0]   c_MAX_COUNT  = (PADDR_W+1)'(2**PADDR_W);
    localparam logic [PADDR_W:0]   c_COUNT_ONE  = (PADDR_W+1)'(1);
    localparam logic [PADDR_W-1:0] c_IDX_ONE    = PADDR_W'(1);
    localparam logic [7:0]         c_DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

    logic [1:0]         r_state;
    logic [PADDR_W-1:0] r_idx;
    logic [PADDR_W:0]   r_count;
    logic               r_bank;
    logic [7:0]         r_drain_cnt;

    logic [PADDR_W:0]   w_count_clamped;
    logic               w_is_last;

    assign w_count_clamped = (cell_count > c_MAX_COUNT) ? c_MAX_COUNT : cell_count;
    assign w_is_last       = ({1'b0, r_idx} == (r_count - c_COUNT_ONE));

    // Outputs are pure decodes of registered state, so no input reaches an output combinationally.
    assign rd.rd_valid  = (r_state == c_ISSUE);
    assign rd.rd_addr   = {r_bank, r_idx};
    assign rd.rd_last   = (r_state == c_ISSUE) && w_is_last;
    assign phase1_done  = (r_state == c_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_idx       <= '0;
            r_count     <= '0;
            r_bank      <= 1'b0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (phase1_ready) begin
                        r_bank      <= double_buffer;
                        r_count     <= w_count_clamped;
                        r_idx       <= '0;
                        r_drain_cnt <= '0;
                        r_state     <= (w_count_clamped == '0) ? c_DRAIN : c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (rd.rd_ready) begin
                        if (w_is_last) begin
                            r_drain_cnt <= '0;
                            r_state     <= c_DRAIN;
                        end else begin
                            r_idx <= r_idx + c_IDX_ONE;
                        end
                    end
                end
                c_DRAIN: begin
                    // Once saturated the counter parks and only pipe_busy holds us here.
                    if (r_drain_cnt == c_DRAIN_LAST) begin
                        if (!rd.pipe_busy) begin
                            r_state <= c_DONE;
                        end
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 8'd1;
                    end
                end
                c_DONE: begin
                    if (!phase1_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
